hub75_scan_ctrl: RTL

Scan and bit-plane scheduler for the 64x64 HUB75 matrix (1/32 scan, two row halves driven in parallel). It fetches pixel bits from a framebuffer read port, shifts one bit-plane of one row pair into the panel, and latches it. It times each plane's display period with binary-coded modulation (BCM) and applies a global brightness duty on the blank (OE) pin. Shifting of the next plane overlaps display of the current one. The block sits between the framebuffer and the panel pin assignments in main.

---
 rtl/hub75_scan_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: fetches, shifts and latches BCM bit-planes into a 1/32-scan HUB75 panel
// Shifting of the next plane overlaps display of the current one; OE carries a 64-step brightness duty.
module hub75_scan_ctrl #(
  parameter int WIDTH     = 64,
  parameter int ROWS      = 32,
  parameter int BIT_DEPTH = 8,
  parameter int BASE_TIME = 64
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [6:0] bright,
  output logic       px_req,
  output logic [5:0] px_col,
  output logic [4:0] px_row,
  output logic [2:0] px_plane,
  input  logic       px_ack,
  input  logic [5:0] px_data,
  output logic       ctrl_oe,
  output logic       ctrl_clk,
  output logic       ctrl_lat,
  output logic [4:0] addr,
  output logic [5:0] col,
  output logic       frame_done
);
  localparam int DW = $clog2(BASE_TIME << (BIT_DEPTH - 1)) + 1;
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH     = 3'd1;
  localparam logic [2:0] WAIT      = 3'd2;
  localparam logic [2:0] SHIFT_LO  = 3'd3;
  localparam logic [2:0] SHIFT_HI  = 3'd4;
  localparam logic [2:0] WAIT_DISP = 3'd5;
  localparam logic [2:0] BLANK     = 3'd6;
  localparam logic [2:0] LATCH     = 3'd7;
  logic [2:0]    state, nxt;
  logic [DW-1:0] dcnt;
  logic [5:0]    ccol;
  logic [4:0]    row;
  logic [2:0]    plane;
  logic          last_col, plane_last, row_last;
  assign last_col   = ccol == 6'(WIDTH - 1);
  assign plane_last = plane == 3'(BIT_DEPTH - 1);
  assign row_last   = row == 5'(ROWS - 1);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:      nxt = enable ? FETCH : IDLE;
      FETCH:     nxt = WAIT;
      WAIT:      nxt = px_ack ? SHIFT_LO : WAIT;
      SHIFT_LO:  nxt = SHIFT_HI;
      SHIFT_HI:  nxt = last_col ? WAIT_DISP : FETCH;
      WAIT_DISP: nxt = (dcnt == '0) ? BLANK : WAIT_DISP;
      BLANK:     nxt = LATCH;
      LATCH:     nxt = enable ? FETCH : IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      dcnt       <= '0;
      ccol       <= '0;
      row        <= '0;
      plane      <= '0;
      addr       <= '0;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt;
      frame_done <= state == LATCH && plane_last && row_last;
      if (state == WAIT && px_ack) col <= px_data;
      if (state == SHIFT_HI) ccol <= last_col ? '0 : ccol + 1'b1;
      // the display counter is reloaded only on latch, so addr and the plane it shows always move together
      if (state == LATCH) begin
        addr  <= row;
        dcnt  <= DW'(BASE_TIME) << plane;
        plane <= plane_last ? '0 : plane + 1'b1;
        if (plane_last) row <= row_last ? '0 : row + 1'b1;
      end else if (dcnt != '0) begin
        dcnt <= dcnt - 1'b1;
      end
    end
  end
  assign px_req   = state == FETCH;
  assign px_col   = ccol;
  assign px_row   = row;
  assign px_plane = plane;
  assign ctrl_clk = state == SHIFT_HI;
  assign ctrl_lat = state == LATCH;
  assign ctrl_oe  = !(dcnt != '0 && {1'b0, dcnt[5:0]} < bright && state != BLANK && state != LATCH);
endmodule
